// File: rtl/bus_arb_pkg.sv
// Shared types and constants for the system-bus grant arbiter and its helpers.
package bus_arb_pkg;

  // Width of a requester index; covers up to 7 requesters.
  localparam int IDX_W = 3;

  // Requester with fixed highest priority (video).
  localparam int PRI_IDX = 0;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    OWNED   = 2'd1,
    RELEASE = 2'd2
  } arb_state_t;

endpackage

// File: rtl/bus_grant_arbiter_rr_pick.sv
// rr_pick: combinational rotating-priority finder.
// Searches req[1..NREQ-1] upward from rr_ptr, wrapping back to 1; index 0 is
// never considered here so a fixed-priority requester can be layered on top.
module rr_pick
  import bus_arb_pkg::*;
#(
  parameter int NREQ = 4
) (
  input  logic [NREQ-1:0]  req,
  input  logic [IDX_W-1:0] rr_ptr,
  output logic [IDX_W-1:0] winner,
  output logic             valid
);

  // Pad the request vector so any IDX_W-bit index selects a real bit.
  logic [(1<<IDX_W)-1:0] req_pad;
  assign req_pad = (1<<IDX_W)'(req);

  // First requested index at or after rr_ptr within the rotating range 1..NREQ-1.
  always_comb begin
    int start;
    int pos;
    logic [IDX_W-1:0] idx;
    // NOTE: every output gets a default before the search so no path leaves it
    // unassigned, which would otherwise infer a latch.
    winner = '0;
    valid  = 1'b0;
    idx    = '0;
    start  = (int'(rr_ptr) >= 1 && int'(rr_ptr) < NREQ) ? int'(rr_ptr) : 1;
    for (int k = 0; k < NREQ - 1; k++) begin
      pos = start + k;
      if (pos >= NREQ) pos = pos - (NREQ - 1);
      idx = IDX_W'(pos);
      if (!valid && req_pad[idx]) begin
        winner = idx;
        valid  = 1'b1;
      end
    end
  end

endmodule

// File: rtl/bus_grant_arbiter.sv
// bus_grant_arbiter: single-owner arbiter for the shared system bus.
// Requester 0 has fixed priority; the rest rotate round-robin. Every ownership
// is followed by one RELEASE cycle with all grants low before re-arbitration.
// Optional macro ARB_TIMEOUT_EN: forces release of a non-zero owner after
// MAX_HOLD owned cycles when someone else is waiting, pulsing TIMEOUT.
module bus_grant_arbiter
  import bus_arb_pkg::*;
#(
  parameter int NREQ     = 4,
  parameter int MAX_HOLD = 16,
  parameter int CW       = 5
) (
  input  logic             CLOCK,
  input  logic             RESET,
  input  logic [NREQ-1:0]  REQ,
  output logic [NREQ-1:0]  GNT,
  output logic [IDX_W-1:0] OWNER,
  output logic             BUSY,
  output logic             QUIET_N,
  output logic             TIMEOUT
);

  // Reject illegal configurations at elaboration.
  if (NREQ < 2 || NREQ > 7 || MAX_HOLD < 2 || (1 << CW) <= MAX_HOLD) begin : g_bad_cfg
    $error("bus_grant_arbiter: illegal NREQ/MAX_HOLD/CW combination");
  end

  arb_state_t       state;
  logic [IDX_W-1:0] rr_ptr;
  logic [IDX_W-1:0] rr_win;
  logic             rr_valid;
  logic [IDX_W-1:0] win_idx;
  logic             any_req;
  logic             owner_req;
  logic             others_req;
  logic             timeout_hit;
  logic [IDX_W-1:0] next_ptr;
  logic [(1<<IDX_W)-1:0] req_pad;

  rr_pick #(.NREQ(NREQ)) u_rr_pick (
    .req    (REQ),
    .rr_ptr (rr_ptr),
    .winner (rr_win),
    .valid  (rr_valid)
  );

  assign req_pad    = (1<<IDX_W)'(REQ);
  assign any_req    = REQ[PRI_IDX] | rr_valid;
  assign win_idx    = REQ[PRI_IDX] ? IDX_W'(PRI_IDX) : rr_win;
  assign owner_req  = req_pad[OWNER];
  // In OWNED, GNT is exactly the owner's bit, so this is "anyone else waiting".
  assign others_req = |(REQ & ~GNT);
  assign next_ptr   = (int'(OWNER) + 1 >= NREQ) ? IDX_W'(1) : OWNER + IDX_W'(1);
  assign BUSY       = (state == OWNED) || (state == RELEASE);

`ifdef ARB_TIMEOUT_EN
  logic [CW-1:0] hold_cnt;

  // An owner that is itself dropping REQ takes the normal release path instead.
  assign timeout_hit = (state == OWNED) && owner_req && others_req &&
                       (hold_cnt == CW'(MAX_HOLD - 1)) &&
                       (OWNER != IDX_W'(PRI_IDX));

  // Count owned cycles (saturating) and pulse TIMEOUT on a forced release.
  always_ff @(posedge CLOCK) begin
    if (RESET) begin
      hold_cnt <= '0;
      TIMEOUT  <= 1'b0;
    end else begin
      TIMEOUT <= timeout_hit;
      if (state == OWNED) begin
        if (hold_cnt != CW'(MAX_HOLD)) hold_cnt <= hold_cnt + 1'b1;
      end else begin
        hold_cnt <= '0;
      end
    end
  end
`else
  assign timeout_hit = 1'b0;
  assign TIMEOUT     = 1'b0;
`endif

  // Ownership sequencing, registered grants and the registered all-quiet flag.
  always_ff @(posedge CLOCK) begin
    if (RESET) begin
      // NOTE: sequential state uses non-blocking assignments so every register
      // samples pre-edge values regardless of statement order.
      state   <= IDLE;
      rr_ptr  <= IDX_W'(1);
      GNT     <= '0;
      OWNER   <= '0;
      QUIET_N <= 1'b0;
    end else begin
      QUIET_N <= (|GNT) | (|REQ);
      case (state)
        IDLE: begin
          if (any_req) begin
            GNT   <= NREQ'(1) << win_idx;
            OWNER <= win_idx;
            state <= OWNED;
          end
        end
        OWNED: begin
          if (!owner_req || timeout_hit) begin
            GNT   <= '0;
            state <= RELEASE;
          end
        end
        RELEASE: begin
          state <= IDLE;
          if (OWNER != IDX_W'(PRI_IDX)) rr_ptr <= next_ptr;
        end
        default: begin
          GNT   <= '0;
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_bus_grant_arbiter.sv
// Directed bench for bus_grant_arbiter (NREQ=4, MAX_HOLD=16).
// Each step drives REQ/RESET, queues the outputs expected after the next
// rising edge, then pops and compares them 1 ns after that edge.
module tb_bus_grant_arbiter;

  logic       CLOCK = 1'b0;
  logic       RESET;
  logic [3:0] REQ;
  logic [3:0] GNT;
  logic [2:0] OWNER;
  logic       BUSY;
  logic       QUIET_N;
  logic       TIMEOUT;

  int errors = 0;
  int checks = 0;

  typedef struct {
    string      tag;
    logic [3:0] gnt;
    logic [2:0] owner;
    logic       busy;
    logic       qn;
    logic       to;
  } exp_t;

  exp_t sb_q[$];

  bus_grant_arbiter #(.NREQ(4), .MAX_HOLD(16), .CW(5)) dut (
    .CLOCK   (CLOCK),
    .RESET   (RESET),
    .REQ     (REQ),
    .GNT     (GNT),
    .OWNER   (OWNER),
    .BUSY    (BUSY),
    .QUIET_N (QUIET_N),
    .TIMEOUT (TIMEOUT)
  );

  always #5 CLOCK = ~CLOCK;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic compare();
    exp_t e;
    checks++;
    assert (sb_q.size() != 0) else begin
      errors++;
      $error("FAIL scoreboard: observed empty queue expected an entry");
      return;
    end
    e = sb_q.pop_front();
    check({e.tag, ".gnt"},     32'(GNT),     32'(e.gnt));
    check({e.tag, ".owner"},   32'(OWNER),   32'(e.owner));
    check({e.tag, ".busy"},    32'(BUSY),    32'(e.busy));
    check({e.tag, ".quiet_n"}, 32'(QUIET_N), 32'(e.qn));
    check({e.tag, ".timeout"}, 32'(TIMEOUT), 32'(e.to));
  endtask

  task automatic step(input string tag, input logic rst, input logic [3:0] req,
                      input logic [3:0] g, input logic [2:0] o,
                      input logic b, input logic q, input logic t);
    exp_t e;
    RESET = rst;
    REQ   = req;
    e.tag = tag; e.gnt = g; e.owner = o; e.busy = b; e.qn = q; e.to = t;
    sb_q.push_back(e);
    @(posedge CLOCK);
    #1;
    compare();
  endtask

  initial begin
    // Reset state.
    step("rst0", 1, 4'b0000, 4'b0000, 3'd0, 0, 0, 0);
    step("rst1", 1, 4'b0000, 4'b0000, 3'd0, 0, 0, 0);

    // Single requester 2: grant on the edge after REQ is seen.
    step("a_idle", 0, 4'b0000, 4'b0000, 3'd0, 0, 0, 0);
    step("a_gnt",  0, 4'b0100, 4'b0100, 3'd2, 1, 1, 0);
    step("a_hold", 0, 4'b0100, 4'b0100, 3'd2, 1, 1, 0);
    step("a_drop", 0, 4'b0000, 4'b0000, 3'd2, 1, 1, 0);
    step("a_rel",  0, 4'b0000, 4'b0000, 3'd2, 0, 0, 0);

    // Reset again so the rotation starts at requester 1.
    step("rst2", 1, 4'b0000, 4'b0000, 3'd0, 0, 0, 0);

    // All request: 0 wins, then 1,2,3,1 with RELEASE and IDLE gaps.
    step("b_g0",    0, 4'b1111, 4'b0001, 3'd0, 1, 1, 0);
    step("b_h0",    0, 4'b1111, 4'b0001, 3'd0, 1, 1, 0);
    step("b_r0",    0, 4'b1110, 4'b0000, 3'd0, 1, 1, 0);
    step("b_i0",    0, 4'b1110, 4'b0000, 3'd0, 0, 1, 0);
    step("b_g1",    0, 4'b1110, 4'b0010, 3'd1, 1, 1, 0);
    step("b_h1",    0, 4'b1110, 4'b0010, 3'd1, 1, 1, 0);
    step("b_r1",    0, 4'b1100, 4'b0000, 3'd1, 1, 1, 0);
    step("b_i1",    0, 4'b1110, 4'b0000, 3'd1, 0, 1, 0);
    step("b_g2",    0, 4'b1110, 4'b0100, 3'd2, 1, 1, 0);
    step("b_h2",    0, 4'b1110, 4'b0100, 3'd2, 1, 1, 0);
    step("b_r2",    0, 4'b1010, 4'b0000, 3'd2, 1, 1, 0);
    step("b_i2",    0, 4'b1110, 4'b0000, 3'd2, 0, 1, 0);
    step("b_g3",    0, 4'b1110, 4'b1000, 3'd3, 1, 1, 0);
    step("b_h3",    0, 4'b1110, 4'b1000, 3'd3, 1, 1, 0);
    step("b_r3",    0, 4'b0110, 4'b0000, 3'd3, 1, 1, 0);
    step("b_i3",    0, 4'b1110, 4'b0000, 3'd3, 0, 1, 0);
    step("b_g1b",   0, 4'b1110, 4'b0010, 3'd1, 1, 1, 0);
    step("b_r1b",   0, 4'b0000, 4'b0000, 3'd1, 1, 1, 0);
    step("b_i1b",   0, 4'b0000, 4'b0000, 3'd1, 0, 0, 0);

    // Owner 3 drops as REQ[0] rises: no preemption, 0 next; pointer wraps to 1.
    step("c_g3",    0, 4'b1000, 4'b1000, 3'd3, 1, 1, 0);
    step("c_h3",    0, 4'b1000, 4'b1000, 3'd3, 1, 1, 0);
    step("c_r3",    0, 4'b0001, 4'b0000, 3'd3, 1, 1, 0);
    step("c_i3",    0, 4'b0001, 4'b0000, 3'd3, 0, 1, 0);
    step("c_g0",    0, 4'b0001, 4'b0001, 3'd0, 1, 1, 0);
    step("c_r0",    0, 4'b0110, 4'b0000, 3'd0, 1, 1, 0);
    step("c_i0",    0, 4'b0110, 4'b0000, 3'd0, 0, 1, 0);
    step("c_g1",    0, 4'b0110, 4'b0010, 3'd1, 1, 1, 0);
    step("c_r1",    0, 4'b0000, 4'b0000, 3'd1, 1, 1, 0);
    step("c_i1",    0, 4'b0000, 4'b0000, 3'd1, 0, 0, 0);

    // Owner 1 holds with REQ[2] pending.
    step("d_g1",    0, 4'b0010, 4'b0010, 3'd1, 1, 1, 0);
    for (int k = 1; k <= 15; k++)
      step($sformatf("d_hold%0d", k), 0, 4'b0110, 4'b0010, 3'd1, 1, 1, 0);
`ifdef ARB_TIMEOUT_EN
    step("d_tmo",   0, 4'b0110, 4'b0000, 3'd1, 1, 1, 1);
    step("d_idle",  0, 4'b0110, 4'b0000, 3'd1, 0, 1, 0);
    step("d_g2",    0, 4'b0110, 4'b0100, 3'd2, 1, 1, 0);
    step("d_r2",    0, 4'b0000, 4'b0000, 3'd2, 1, 1, 0);
    step("d_i2",    0, 4'b0000, 4'b0000, 3'd2, 0, 0, 0);
`else
    for (int k = 16; k <= 24; k++)
      step($sformatf("d_hold%0d", k), 0, 4'b0110, 4'b0010, 3'd1, 1, 1, 0);
    step("d_r1",    0, 4'b0000, 4'b0000, 3'd1, 1, 1, 0);
    step("d_i1",    0, 4'b0000, 4'b0000, 3'd1, 0, 0, 0);
`endif

    // Owner 0 is never timed out, even with REQ[1] waiting for 40 cycles.
    step("e_g0",    0, 4'b0001, 4'b0001, 3'd0, 1, 1, 0);
    for (int k = 1; k <= 40; k++)
      step($sformatf("e_hold%0d", k), 0, 4'b0011, 4'b0001, 3'd0, 1, 1, 0);
    step("e_r0",    0, 4'b0010, 4'b0000, 3'd0, 1, 1, 0);
    step("e_i0",    0, 4'b0000, 4'b0000, 3'd0, 0, 0, 0);

    // Reset while owner 2 holds: abrupt grant loss, regrant right after release of reset.
    step("f_g2",    0, 4'b0100, 4'b0100, 3'd2, 1, 1, 0);
    step("f_h2",    0, 4'b0100, 4'b0100, 3'd2, 1, 1, 0);
    step("f_rst",   1, 4'b0100, 4'b0000, 3'd0, 0, 0, 0);
    step("f_reg2",  0, 4'b0100, 4'b0100, 3'd2, 1, 1, 0);
    step("f_r2",    0, 4'b0000, 4'b0000, 3'd2, 1, 1, 0);
    step("f_i2",    0, 4'b0000, 4'b0000, 3'd2, 0, 0, 0);

    check("sb_drained", 32'(sb_q.size()), 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
